alu_issue: RTL and testbench

Operand-issue stage sitting directly upstream of the 32-bit combinational `alu`. It accepts micro-instructions (op, rd, rs1, rs2, optional immediate) over a valid/ready handshake and reads operands from a small register file. It drives the ALU's `a`/`b`/`op` from a registered execute slot, then captures `y`/`zero` into a writeback register that also updates the register file. It closes the loop around the ALU so the pair can be verified as a tiny pipelined datapath.

---
 rtl/alu_pkg.sv | 27 ++
 rtl/alu_regfile.sv | 48 ++++
 rtl/alu_issue.sv | 125 ++++++++++++
 tb/tb_alu_issue.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
//------------------------------------------------------------------------------
// Module : alu_pkg
// Brief  : Opcode encoding and default width shared by the ALU, its issue
//          stage and their benches.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package alu_pkg;

    localparam int ALU_W_DEFAULT = 32;
    localparam int ALU_OP_W      = 4;

    typedef enum logic [ALU_OP_W-1:0] {
        ALU_ADD = 4'd0,
        ALU_SUB = 4'd1,
        ALU_AND = 4'd2,
        ALU_OR  = 4'd3,
        ALU_XOR = 4'd4,
        ALU_SLT = 4'd5,
        ALU_SLL = 4'd6,
        ALU_SRL = 4'd7
    } alu_op_e;

endpackage

`default_nettype wire

// File: rtl/alu_regfile.sv
//------------------------------------------------------------------------------
// Module : alu_regfile
// Brief  : NREG x W register file, two async read ports plus a debug read
//          port, one synchronous write port, r0 hardwired to zero.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module alu_regfile
    import alu_pkg::*;
#(
    parameter int W    = ALU_W_DEFAULT,
    parameter int NREG = 8,
    localparam int RW  = $clog2(NREG)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we_i,
    input  logic [RW-1:0] waddr_i,
    input  logic [W-1:0]  wdata_i,
    input  logic [RW-1:0] raddr1_i,
    output logic [W-1:0]  rdata1_o,
    input  logic [RW-1:0] raddr2_i,
    output logic [W-1:0]  rdata2_o,
    input  logic [RW-1:0] dbg_addr_i,
    output logic [W-1:0]  dbg_data_o
);

    logic [W-1:0] mem_q [NREG];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i && (waddr_i != '0)) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // r0 is forced to zero on read so its storage never matters.
    assign rdata1_o   = (raddr1_i   == '0) ? '0 : mem_q[raddr1_i];
    assign rdata2_o   = (raddr2_i   == '0) ? '0 : mem_q[raddr2_i];
    assign dbg_data_o = (dbg_addr_i == '0) ? '0 : mem_q[dbg_addr_i];

endmodule

`default_nettype wire

// File: rtl/alu_issue.sv
//------------------------------------------------------------------------------
// Module : alu_issue
// Brief  : Operand-issue stage (EX slot + WB register) wrapped around an
//          external combinational ALU. Define ALU_ISSUE_FWD_EN to forward the
//          ALU result instead of stalling on a read-after-write hazard.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module alu_issue
    import alu_pkg::*;
#(
    parameter int W    = ALU_W_DEFAULT,
    parameter int NREG = 8,
    localparam int RW  = $clog2(NREG)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [3:0]    in_op,
    input  logic [RW-1:0] in_rd,
    input  logic [RW-1:0] in_rs1,
    input  logic [RW-1:0] in_rs2,
    input  logic          in_imm_sel,
    input  logic [W-1:0]  in_imm,
    output logic [W-1:0]  alu_a,
    output logic [W-1:0]  alu_b,
    output logic [3:0]    alu_op,
    input  logic [W-1:0]  alu_y,
    input  logic          alu_zero,
    output logic          wb_valid,
    output logic [RW-1:0] wb_rd,
    output logic [W-1:0]  wb_data,
    output logic          wb_zero,
    input  logic [RW-1:0] dbg_addr,
    output logic [W-1:0]  dbg_data
);

    logic          ex_valid_q;
    logic [RW-1:0] ex_rd_q;
    logic [W-1:0]  ex_a_q, ex_b_q;
    logic [3:0]    ex_op_q;
    logic          wb_valid_q, wb_zero_q;
    logic [RW-1:0] wb_rd_q;
    logic [W-1:0]  wb_data_q;

    logic [W-1:0]  rf_rdata1, rf_rdata2;
    logic [W-1:0]  ex_a_d, ex_b_d;
    logic          hz_rs1, hz_rs2, stall, fire;

    alu_regfile #(
        .W    (W),
        .NREG (NREG)
    ) u_regfile (
        .clk        (clk),
        .rst        (rst),
        .we_i       (ex_valid_q),
        .waddr_i    (ex_rd_q),
        .wdata_i    (alu_y),
        .raddr1_i   (in_rs1),
        .rdata1_o   (rf_rdata1),
        .raddr2_i   (in_rs2),
        .rdata2_o   (rf_rdata2),
        .dbg_addr_i (dbg_addr),
        .dbg_data_o (dbg_data)
    );

    // The instruction in EX writes back at the same edge a new one issues,
    // so the regfile read here would be one value stale.
    assign hz_rs1 = ex_valid_q && (ex_rd_q != '0) && (in_rs1 == ex_rd_q);
    assign hz_rs2 = ex_valid_q && (ex_rd_q != '0) && !in_imm_sel && (in_rs2 == ex_rd_q);

`ifdef ALU_ISSUE_FWD_EN
    assign stall  = 1'b0;
    assign ex_a_d = hz_rs1 ? alu_y : rf_rdata1;
    assign ex_b_d = in_imm_sel ? in_imm : (hz_rs2 ? alu_y : rf_rdata2);
`else
    assign stall  = in_valid && (hz_rs1 || hz_rs2);
    assign ex_a_d = rf_rdata1;
    assign ex_b_d = in_imm_sel ? in_imm : rf_rdata2;
`endif

    assign in_ready = !rst && !stall;
    assign fire     = in_valid && in_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_valid_q <= 1'b0;
            ex_rd_q    <= '0;
            ex_a_q     <= '0;
            ex_b_q     <= '0;
            ex_op_q    <= '0;
            wb_valid_q <= 1'b0;
            wb_rd_q    <= '0;
            wb_data_q  <= '0;
            wb_zero_q  <= 1'b0;
        end else begin
            ex_valid_q <= fire;
            if (fire) begin
                ex_rd_q <= in_rd;
                ex_a_q  <= ex_a_d;
                ex_b_q  <= ex_b_d;
                ex_op_q <= in_op;
            end
            wb_valid_q <= ex_valid_q;
            if (ex_valid_q) begin
                wb_rd_q   <= ex_rd_q;
                wb_data_q <= alu_y;
                wb_zero_q <= alu_zero;
            end
        end
    end

    assign alu_a    = ex_a_q;
    assign alu_b    = ex_b_q;
    assign alu_op   = ex_op_q;
    assign wb_valid = wb_valid_q;
    assign wb_rd    = wb_rd_q;
    assign wb_data  = wb_data_q;
    assign wb_zero  = wb_zero_q;

endmodule

`default_nettype wire

// File: tb/tb_alu_issue.sv
//------------------------------------------------------------------------------
// Module : tb_alu_issue
// Brief  : Directed bench for alu_issue with a behavioural ALU closing the
//          loop; follows ALU_ISSUE_FWD_EN for hazard timing.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_alu_issue;
    import alu_pkg::*;

    localparam int W    = 32;
    localparam int NREG = 8;
    localparam int RW   = 3;

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [3:0]    in_op;
    logic [RW-1:0] in_rd, in_rs1, in_rs2;
    logic          in_imm_sel;
    logic [W-1:0]  in_imm;
    logic [W-1:0]  alu_a, alu_b, alu_y;
    logic [3:0]    alu_op;
    logic          alu_zero;
    logic          wb_valid;
    logic [RW-1:0] wb_rd;
    logic [W-1:0]  wb_data;
    logic          wb_zero;
    logic [RW-1:0] dbg_addr;
    logic [W-1:0]  dbg_data;

    int n_asrt = 0;
    int n_fail = 0;

    alu_issue #(.W(W), .NREG(NREG)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_rd      (in_rd),
        .in_rs1     (in_rs1),
        .in_rs2     (in_rs2),
        .in_imm_sel (in_imm_sel),
        .in_imm     (in_imm),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_op     (alu_op),
        .alu_y      (alu_y),
        .alu_zero   (alu_zero),
        .wb_valid   (wb_valid),
        .wb_rd      (wb_rd),
        .wb_data    (wb_data),
        .wb_zero    (wb_zero),
        .dbg_addr   (dbg_addr),
        .dbg_data   (dbg_data)
    );

    // Reference ALU sitting downstream of the issue stage.
    always_comb begin
        alu_y = '0;
        case (alu_op)
            4'd0:    alu_y = alu_a + alu_b;
            4'd1:    alu_y = alu_a - alu_b;
            4'd2:    alu_y = alu_a & alu_b;
            4'd3:    alu_y = alu_a | alu_b;
            4'd4:    alu_y = alu_a ^ alu_b;
            4'd5:    alu_y = {31'd0, $signed(alu_a) < $signed(alu_b)};
            4'd6:    alu_y = alu_a << alu_b[4:0];
            4'd7:    alu_y = alu_a >> alu_b[4:0];
            default: alu_y = '0;
        endcase
    end
    assign alu_zero = (alu_y == '0);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asrt++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [3:0] op, input logic [RW-1:0] rd, input logic [RW-1:0] rs1,
                         input logic [RW-1:0] rs2, input logic sel, input logic [W-1:0] imm);
        in_valid   = 1'b1;
        in_op      = op;
        in_rd      = rd;
        in_rs1     = rs1;
        in_rs2     = rs2;
        in_imm_sel = sel;
        in_imm     = imm;
    endtask

    // Isolated instruction: issue, then check writeback exactly two edges later.
    task automatic run1(input string tag, input logic [3:0] op, input logic [RW-1:0] rd,
                        input logic [RW-1:0] rs1, input logic [RW-1:0] rs2, input logic sel,
                        input logic [W-1:0] imm, input logic [W-1:0] exp_d, input logic exp_z);
        @(negedge clk);
        drive(op, rd, rs1, rs2, sel, imm);
        #1 chk({tag, ".ready"}, {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        chk({tag, ".wb_early"}, {31'd0, wb_valid}, 32'd0);
        @(negedge clk);
        chk({tag, ".wb_valid"}, {31'd0, wb_valid}, 32'd1);
        chk({tag, ".wb_rd"},    {29'd0, wb_rd},    {29'd0, rd});
        chk({tag, ".wb_data"},  wb_data,           exp_d);
        chk({tag, ".wb_zero"},  {31'd0, wb_zero},  {31'd0, exp_z});
        dbg_addr = rd;
        #1 chk({tag, ".dbg"}, dbg_data, (rd == '0) ? 32'd0 : exp_d);
        @(negedge clk);
        chk({tag, ".wb_pulse"}, {31'd0, wb_valid}, 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0; in_op = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0;
        in_imm_sel = 1'b0; in_imm = '0; dbg_addr = '0;

        repeat (2) @(negedge clk);
        chk("rst.ready",    {31'd0, in_ready}, 32'd0);
        chk("rst.wb_valid", {31'd0, wb_valid}, 32'd0);
        chk("rst.wb_data",  wb_data,           32'd0);
        chk("rst.alu_a",    alu_a,             32'd0);
        rst = 1'b0;

        // Dependent chain: r1=10, r2=5, r3=r1-r2.
        @(negedge clk);
        drive(ALU_ADD, 3'd1, 3'd0, 3'd0, 1'b1, 32'd10);
        #1 chk("chain.ready_a", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        drive(ALU_ADD, 3'd2, 3'd0, 3'd0, 1'b1, 32'd5);
        #1;
        chk("chain.alu_a0", alu_a, 32'd0);
        chk("chain.alu_b0", alu_b, 32'd10);
        chk("chain.alu_op0", {28'd0, alu_op}, 32'd0);
        chk("chain.ready_b", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        chk("chain.wb_v1", {31'd0, wb_valid}, 32'd1);
        chk("chain.wb_rd1", {29'd0, wb_rd}, 32'd1);
        chk("chain.wb_d1", wb_data, 32'd10);
        drive(ALU_SUB, 3'd3, 3'd1, 3'd2, 1'b0, 32'd0);
`ifdef ALU_ISSUE_FWD_EN
        #1 chk("chain.ready_c", {31'd0, in_ready}, 32'd1);
`else
        #1 chk("chain.stall_c", {31'd0, in_ready}, 32'd0);
`endif
        @(negedge clk);
        chk("chain.wb_v2", {31'd0, wb_valid}, 32'd1);
        chk("chain.wb_rd2", {29'd0, wb_rd}, 32'd2);
        chk("chain.wb_d2", wb_data, 32'd5);
`ifdef ALU_ISSUE_FWD_EN
        in_valid = 1'b0;
`else
        #1 chk("chain.ready_c2", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        chk("chain.bubble", {31'd0, wb_valid}, 32'd0);
`endif
        chk("chain.alu_a2", alu_a, 32'd10);
        chk("chain.alu_b2", alu_b, 32'd5);
        chk("chain.alu_op2", {28'd0, alu_op}, 32'd1);
        @(negedge clk);
        chk("chain.wb_v3", {31'd0, wb_valid}, 32'd1);
        chk("chain.wb_rd3", {29'd0, wb_rd}, 32'd3);
        chk("chain.wb_d3", wb_data, 32'd5);
        dbg_addr = 3'd3;
        #1 chk("chain.dbg_r3", dbg_data, 32'd5);

        // r0 writes are discarded but still retire.
        run1("r0add", ALU_ADD, 3'd0, 3'd0, 3'd0, 1'b1, 32'd7, 32'd7, 1'b0);
        run1("or_r0", ALU_OR,  3'd4, 3'd0, 3'd0, 1'b0, 32'd0, 32'd0, 1'b1);
        run1("sub_m1", ALU_SUB, 3'd5, 3'd0, 3'd0, 1'b1, 32'd1, 32'hFFFF_FFFF, 1'b0);
        run1("slt",    ALU_SLT, 3'd6, 3'd5, 3'd0, 1'b1, 32'd1, 32'd1, 1'b0);
        run1("srl",    ALU_SRL, 3'd7, 3'd5, 3'd0, 1'b1, 32'd36, 32'h0FFF_FFFF, 1'b0);
        run1("set3",   ALU_ADD, 3'd1, 3'd0, 3'd0, 1'b1, 32'd3, 32'd3, 1'b0);
        run1("illegal", 4'hC,   3'd2, 3'd1, 3'd0, 1'b1, 32'd4, 32'd0, 1'b1);

        // Asynchronous reset while an instruction sits in EX.
        @(negedge clk);
        drive(ALU_ADD, 3'd3, 3'd0, 3'd0, 1'b1, 32'd99);
        @(posedge clk);
        #1 rst = 1'b1;
        in_valid = 1'b0;
        #1;
        chk("mid.ready",   {31'd0, in_ready}, 32'd0);
        chk("mid.wb_valid", {31'd0, wb_valid}, 32'd0);
        chk("mid.wb_rd",   {29'd0, wb_rd},    32'd0);
        chk("mid.wb_data", wb_data,           32'd0);
        chk("mid.wb_zero", {31'd0, wb_zero},  32'd0);
        chk("mid.alu_a",   alu_a,             32'd0);
        chk("mid.alu_b",   alu_b,             32'd0);
        chk("mid.alu_op",  {28'd0, alu_op},   32'd0);
        for (int i = 0; i < NREG; i++) begin
            dbg_addr = i[RW-1:0];
            #1 chk($sformatf("mid.dbg_r%0d", i), dbg_data, 32'd0);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("post.wb_valid%0d", i), {31'd0, wb_valid}, 32'd0);
        end
        chk("post.ready", {31'd0, in_ready}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
